// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and PC step.
package fetch_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_HOLD    = ST_HOLD,
    S_ADVANCE = ST_ADVANCE,
    S_HALTED  = ST_HALTED
  } fetch_state_t;

  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating wait counter for an outstanding imem request.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en && (cnt != CNT_W'(MAX_WAIT)))
      cnt <= cnt + 1'b1;
  end

  // cnt counts completed wait cycles, so this flags the MAX_WAIT-th cycle in REQ
  assign expired = en && (cnt >= CNT_W'(MAX_WAIT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues imem reads at the current PC, presents the
// fetched word to decode, then steps or redirects the program counter.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  output logic               inc_pc,
  output logic               pc_src,
  output logic [ADDR_W-1:0]  next_pc_addr,
  output logic               halted,
  output logic               fetch_fault
);
  fetch_state_t      state;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_tgt;
  logic              timer_expired;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != S_REQ),
    .en      (state == S_REQ),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr       <= '0;
      instr_pc    <= '0;
      redir_pend  <= 1'b0;
      redir_tgt   <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          state <= halt ? S_HALTED : S_REQ;
        S_REQ: begin
          if (redirect_valid) begin
            redir_pend <= 1'b1;
            redir_tgt  <= redirect_target;
          end
          // an arriving ack always beats a timeout in the same cycle
          if (imem_ack) begin
            if (redir_pend || redirect_valid) begin
              state <= halt ? S_HALTED : S_ADVANCE;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc_addr;
              state    <= halt ? S_HALTED : S_HOLD;
            end
          end else if (timer_expired) begin
            fetch_fault <= 1'b1;
            state       <= S_HALTED;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            redir_pend <= 1'b1;
            redir_tgt  <= redirect_target;
            state      <= S_ADVANCE;
          end else if (instr_ready) begin
            state <= halt ? S_HALTED : S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          // a redirect arriving during a plain +4 step is kept for the next fetch
          redir_pend <= redirect_valid && !redir_pend;
          if (redirect_valid && !redir_pend)
            redir_tgt <= redirect_target;
          state <= halt ? S_HALTED : S_REQ;
        end
        S_HALTED:
          state <= S_HALTED;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  assign imem_req     = (state == S_REQ);
  assign imem_addr    = imem_req ? pc_addr : '0;
  assign instr_valid  = (state == S_HOLD);
  assign inc_pc       = (state == S_ADVANCE);
  assign pc_src       = (state == S_ADVANCE) && redir_pend;
  assign next_pc_addr = redir_tgt;
  assign halted       = (state == S_HALTED);
endmodule
